// File: rtl/wrf_pkg.sv
// Shared sizing helpers and address mapping for the register-window file.
package wrf_pkg;

   typedef enum logic {TRAP_IDLE, TRAP_HIT} trapState_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic int strideOf(input int winRegs, input int overlap);
      return winRegs - overlap;
   endfunction

   function automatic int physOf(input int numWin, input int winRegs, input int overlap);
      return numWin * strideOf(winRegs, overlap);
   endfunction

   // Full-width sum before the modulo so the top window wraps onto physical 0.
   function automatic int phys_index(input int cwp, input int addr, input int stride,
                                     input int phys);
      return (cwp * stride + addr) % phys;
   endfunction

endpackage

// File: rtl/windowed_reg_file_if.sv
// Read/write/window-control bundle between the datapath and the register-window file.
interface windowed_reg_file_if
   import wrf_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int WIN_REGS = 4,
   parameter int NUM_WIN  = 4
);
   localparam int AW = clog2(WIN_REGS);
   localparam int WW = clog2(NUM_WIN);

   logic [AW-1:0]     rd_addr1;
   logic [AW-1:0]     rd_addr2;
   logic [DATA_W-1:0] rd_data1;
   logic [DATA_W-1:0] rd_data2;
   logic              wr_en;
   logic [AW-1:0]     wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              call;
   logic              ret;
   logic [WW-1:0]     cwp;
   logic [WW-1:0]     depth;
   logic              ovf_trap;
   logic              unf_trap;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, call, ret,
      input  rd_data1, rd_data2, cwp, depth, ovf_trap, unf_trap
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, call, ret,
      output rd_data1, rd_data2, cwp, depth, ovf_trap, unf_trap
   );

endinterface

// File: rtl/wrf_window_ctrl.sv
// Current-window pointer, nesting depth and one-cycle overflow/underflow trap pulses.
module wrf_window_ctrl
   import wrf_pkg::*;
#(
   parameter int NUM_WIN = 4,
   localparam int WW = clog2(NUM_WIN)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          call,
   input  logic          ret,
   output logic [WW-1:0] cwp,
   output logic [WW-1:0] depth,
   output logic          ovfTrap,
   output logic          unfTrap
);

   localparam logic [WW-1:0] MAX_DEPTH = WW'(NUM_WIN - 1);
   localparam logic [WW-1:0] ONE       = WW'(1);

   trapState_e ovfState;
   trapState_e unfState;

   // Depth stops one short of NUM_WIN so the oldest resident window is never overwritten.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cwp      <= '0;
         depth    <= '0;
         ovfState <= TRAP_IDLE;
         unfState <= TRAP_IDLE;
      end else begin
         ovfState <= TRAP_IDLE;
         unfState <= TRAP_IDLE;
         if (call && !ret) begin
            if (depth != MAX_DEPTH) begin
               cwp   <= cwp + ONE;
               depth <= depth + ONE;
            end else begin
               ovfState <= TRAP_HIT;
            end
         end else if (ret && !call) begin
            if (depth != '0) begin
               cwp   <= cwp - ONE;
               depth <= depth - ONE;
            end else begin
               unfState <= TRAP_HIT;
            end
         end
      end
   end

   assign ovfTrap = (ovfState == TRAP_HIT);
   assign unfTrap = (unfState == TRAP_HIT);

endmodule

// File: rtl/windowed_reg_file.sv
// Register-window file: circular physical array addressed through the current window pointer.
module windowed_reg_file
   import wrf_pkg::*;
#(
   parameter int DATA_W   = 16,
   parameter int WIN_REGS = 4,
   parameter int OVERLAP  = 2,
   parameter int NUM_WIN  = 4
) (
   input logic                 clk,
   input logic                 rst,
   windowed_reg_file_if.slave  bus
);

   localparam int STRIDE = strideOf(WIN_REGS, OVERLAP);
   localparam int PHYS   = physOf(NUM_WIN, WIN_REGS, OVERLAP);
   localparam int PW     = clog2(PHYS);
   localparam int WW     = clog2(NUM_WIN);

   logic [DATA_W-1:0] regs [PHYS];
   logic [WW-1:0]     cwpW;
   logic [PW-1:0]     rdIdx1;
   logic [PW-1:0]     rdIdx2;
   logic [PW-1:0]     wrIdx;

   wrf_window_ctrl #(
      .NUM_WIN (NUM_WIN)
   ) uCtrl (
      .clk     (clk),
      .rst     (rst),
      .call    (bus.call),
      .ret     (bus.ret),
      .cwp     (cwpW),
      .depth   (bus.depth),
      .ovfTrap (bus.ovf_trap),
      .unfTrap (bus.unf_trap)
   );

   assign bus.cwp = cwpW;

   always_comb begin
      rdIdx1 = PW'(phys_index(int'(cwpW), int'(bus.rd_addr1), STRIDE, PHYS));
      rdIdx2 = PW'(phys_index(int'(cwpW), int'(bus.rd_addr2), STRIDE, PHYS));
      wrIdx  = PW'(phys_index(int'(cwpW), int'(bus.wr_addr),  STRIDE, PHYS));
   end

   // No bypass: reads see the array as it stood before the coming edge.
   assign bus.rd_data1 = regs[rdIdx1];
   assign bus.rd_data2 = regs[rdIdx2];

   // The write index uses the pre-edge cwp, so a same-edge call/ret cannot redirect it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHYS; i++) regs[i] <= '0;
      end else if (bus.wr_en) begin
         regs[wrIdx] <= bus.wr_data;
      end
   end

endmodule
